pifo_calendar_gpfc_queue: RTL and testbench

PIFO_CALENDAR_GPFC_QUEUE -- requirements
Module: pifo_calendar_gpfc_queue

---
 rtl/pifo_gpfc_pkg.sv | 41 ++++
 rtl/pifo_gpfc_slot.sv | 109 ++++++++++
 rtl/pifo_calendar_gpfc_queue.sv | 114 +++++++++++
 tb/tb_pifo_calendar_gpfc_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_gpfc_pkg.sv
// ============================================================================
// pifo_gpfc_pkg
// Shared widths, element packing helpers and slot-operation encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pifo_gpfc_pkg;

    localparam int DEF_DEPTH           = 16;
    localparam int DEF_RANK_WIDTH      = 17;
    localparam int DEF_COS_WIDTH       = 3;
    localparam int DEF_GPFC_RANK_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH      = 12;

    // Element packing, MSB first: {overflow, rank, cos, gpfc_rank, addr}
    function automatic int calc_data_width(input int rw, input int cw, input int gw, input int aw);
        return 1 + rw + cw + gw + aw;
    endfunction

    function automatic int calc_rank_lsb(input int cw, input int gw, input int aw);
        return cw + gw + aw;
    endfunction

    localparam int DEF_DATA_WIDTH = calc_data_width(DEF_RANK_WIDTH, DEF_COS_WIDTH,
                                                    DEF_GPFC_RANK_WIDTH, DEF_ADDR_WIDTH);
    localparam int DEF_OVF_POS    = DEF_DATA_WIDTH - 1;
    localparam int DEF_RANK_LSB   = calc_rank_lsb(DEF_COS_WIDTH, DEF_GPFC_RANK_WIDTH,
                                                  DEF_ADDR_WIDTH);

    // Bit 0 = insert fires, bit 1 = pop fires
    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_INS     = 2'b01,
        OP_POP     = 2'b10,
        OP_INS_POP = 2'b11
    } slot_op_e;

endpackage

`default_nettype wire

// File: rtl/pifo_gpfc_slot.sv
// ============================================================================
// pifo_gpfc_slot
// One ordered slot: priority compare against the new element plus next-value mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pifo_gpfc_slot
    import pifo_gpfc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RANK_WIDTH = DEF_RANK_WIDTH,
    parameter int OVF_POS    = DEF_OVF_POS,
    parameter int RANK_LSB   = DEF_RANK_LSB,
    parameter bit IS_HEAD    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_new_data,
    input  logic                  i_global_ovf,
    input  logic                  i_any_prev,
    input  logic                  i_any_next,
    input  logic                  i_prev_valid,
    input  logic [DATA_WIDTH-1:0] i_prev_data,
    input  logic                  i_next_valid,
    input  logic [DATA_WIDTH-1:0] i_next_data,
    output logic                  o_any,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_flag;
    logic [DATA_WIDTH:0]   w_next;
    slot_op_e              w_op;

    logic                  w_new_ovf;
    logic                  w_slot_ovf;
    logic [RANK_WIDTH-1:0] w_new_rank;
    logic [RANK_WIDTH-1:0] w_slot_rank;

    assign w_op        = slot_op_e'(i_op);
    assign w_new_ovf   = i_new_data[OVF_POS];
    assign w_slot_ovf  = r_data[OVF_POS];
    assign w_new_rank  = i_new_data[RANK_LSB +: RANK_WIDTH];
    assign w_slot_rank = r_data[RANK_LSB +: RANK_WIDTH];

    // Elements in the current round (overflow == global) outrank the next round;
    // strict less-than keeps equal keys in arrival order.
    always_comb begin
        w_flag = 1'b0;
        if (!r_valid) begin
            w_flag = 1'b1;
        end else if ((w_new_ovf == i_global_ovf) && (w_slot_ovf != i_global_ovf)) begin
            w_flag = 1'b1;
        end else if ((w_new_ovf != i_global_ovf) && (w_slot_ovf == i_global_ovf)) begin
            w_flag = 1'b0;
        end else begin
            w_flag = (w_new_rank < w_slot_rank);
        end
    end

    // o_any: some slot at or ahead of this one wins the insert compare
    assign o_any = i_any_prev | w_flag;

    // With a concurrent pop, everything ahead of the insert point slides toward the
    // head and the new element lands one position ahead of where it would have gone.
    always_comb begin
        w_next = {r_valid, r_data};
        case (w_op)
            OP_INS: begin
                if (i_any_prev) begin
                    w_next = {i_prev_valid, i_prev_data};
                end else if (w_flag) begin
                    w_next = {1'b1, i_new_data};
                end
            end
            OP_POP: begin
                w_next = {i_next_valid, i_next_data};
            end
            OP_INS_POP: begin
                if (!i_any_next) begin
                    w_next = {i_next_valid, i_next_data};
                end else if (!o_any || IS_HEAD) begin
                    w_next = {1'b1, i_new_data};
                end
            end
            default: w_next = {r_valid, r_data};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_next[DATA_WIDTH];
            r_data  <= w_next[DATA_WIDTH-1:0];
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pifo_calendar_gpfc_queue.sv
// ============================================================================
// pifo_calendar_gpfc_queue
// Shift-register PIFO with calendar-style global overflow rounds and GPFC fields.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pifo_calendar_gpfc_queue
    import pifo_gpfc_pkg::*;
#(
    parameter  int DEPTH           = DEF_DEPTH,
    parameter  int RANK_WIDTH      = DEF_RANK_WIDTH,
    parameter  int COS_WIDTH       = DEF_COS_WIDTH,
    parameter  int GPFC_RANK_WIDTH = DEF_GPFC_RANK_WIDTH,
    parameter  int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    localparam int DATA_WIDTH      = calc_data_width(RANK_WIDTH, COS_WIDTH,
                                                     GPFC_RANK_WIDTH, ADDR_WIDTH),
    localparam int CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_ins_valid,
    input  logic [DATA_WIDTH-1:0] in_ins_data,
    output logic                  out_ins_ready,
    input  logic                  in_pop,
    output logic                  out_head_valid,
    output logic [DATA_WIDTH-1:0] out_head_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_full,
    output logic                  out_empty,
    output logic                  out_global_overflow
);

    localparam int               c_OVF_POS  = DATA_WIDTH - 1;
    localparam int               c_RANK_LSB = calc_rank_lsb(COS_WIDTH, GPFC_RANK_WIDTH,
                                                            ADDR_WIDTH);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             r_global_ovf;
    logic             w_ins;
    logic             w_pop;
    logic [1:0]       w_op;

    // Index k+1 is slot k; indices 0 and DEPTH+1 are fixed boundary neighbours.
    logic                  w_valid_ext [DEPTH+2];
    logic [DATA_WIDTH-1:0] w_data_ext  [DEPTH+2];
    logic                  w_any_ext   [DEPTH+2];

    assign out_full      = (r_count == c_DEPTH);
    assign out_empty     = (r_count == '0);
    assign out_ins_ready = ~out_full | in_pop;
    assign w_ins         = in_ins_valid & out_ins_ready;
    assign w_pop         = in_pop & ~out_empty;
    assign w_op          = {w_pop, w_ins};

    assign w_valid_ext[0]       = 1'b0;
    assign w_data_ext[0]        = '0;
    assign w_any_ext[0]         = 1'b0;
    assign w_valid_ext[DEPTH+1] = 1'b0;
    assign w_data_ext[DEPTH+1]  = '0;
    // A virtual winner past the tail lets a full queue with a concurrent pop
    // place the least significant newcomer in the last slot.
    assign w_any_ext[DEPTH+1]   = 1'b1;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        pifo_gpfc_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .RANK_WIDTH (RANK_WIDTH),
            .OVF_POS    (c_OVF_POS),
            .RANK_LSB   (c_RANK_LSB),
            .IS_HEAD    (gi == 0)
        ) u_slot (
            .clk          (clk),
            .rstn         (rstn),
            .i_op         (w_op),
            .i_new_data   (in_ins_data),
            .i_global_ovf (r_global_ovf),
            .i_any_prev   (w_any_ext[gi]),
            .i_any_next   (w_any_ext[gi+2]),
            .i_prev_valid (w_valid_ext[gi]),
            .i_prev_data  (w_data_ext[gi]),
            .i_next_valid (w_valid_ext[gi+2]),
            .i_next_data  (w_data_ext[gi+2]),
            .o_any        (w_any_ext[gi+1]),
            .o_valid      (w_valid_ext[gi+1]),
            .o_data       (w_data_ext[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count      <= '0;
            r_global_ovf <= 1'b0;
        end else begin
            case ({w_ins, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_global_ovf <= w_data_ext[1][c_OVF_POS];
            end
        end
    end

    assign out_head_valid      = w_valid_ext[1];
    assign out_head_data       = w_data_ext[1];
    assign out_count           = r_count;
    assign out_global_overflow = r_global_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pifo_calendar_gpfc_queue.sv
// ============================================================================
// tb_pifo_calendar_gpfc_queue
// Directed scenarios plus randomized traffic against a sorted-queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pifo_calendar_gpfc_queue;

    localparam int DEPTH = 16;
    localparam int RW    = 17;
    localparam int CW    = 3;
    localparam int GW    = 6;
    localparam int AW    = 12;
    localparam int DW    = 1 + RW + CW + GW + AW;
    localparam int RLSB  = CW + GW + AW;
    localparam int NW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_ins_valid = 1'b0;
    logic [DW-1:0] in_ins_data = '0;
    logic          in_pop = 1'b0;
    logic          out_ins_ready;
    logic          out_head_valid;
    logic [DW-1:0] out_head_data;
    logic [NW-1:0] out_count;
    logic          out_full;
    logic          out_empty;
    logic          out_global_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    logic [DW-1:0] mq[$];
    logic          mgov = 1'b0;

    pifo_calendar_gpfc_queue u_dut (
        .clk                 (clk),
        .rstn                (rstn),
        .in_ins_valid        (in_ins_valid),
        .in_ins_data         (in_ins_data),
        .out_ins_ready       (out_ins_ready),
        .in_pop              (in_pop),
        .out_head_valid      (out_head_valid),
        .out_head_data       (out_head_data),
        .out_count           (out_count),
        .out_full            (out_full),
        .out_empty           (out_empty),
        .out_global_overflow (out_global_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic ovf, input int rank, input int addr);
        logic [RW-1:0] r;
        logic [AW-1:0] a;
        r = RW'(rank);
        a = AW'(addr);
        return {ovf, r, {CW{1'b0}}, {GW{1'b0}}, a};
    endfunction

    function automatic int rank_of(input logic [DW-1:0] d);
        return int'(d[RLSB +: RW]);
    endfunction

    // Sort key: current-round elements (overflow == global) first, then by rank.
    function automatic logic [RW:0] key_of(input logic [DW-1:0] d, input logic g);
        return {(d[DW-1] != g), d[RLSB +: RW]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue sorted by key, updated on each rising edge
    always @(posedge clk) begin
        int  k;
        bit  ins_f;
        bit  pop_f;
        logic [DW-1:0] popped;
        logic gnext;
        if (!rstn) begin
            mq.delete();
            mgov = 1'b0;
        end else begin
            pop_f = in_pop && (mq.size() > 0);
            ins_f = in_ins_valid && ((mq.size() < DEPTH) || in_pop);
            k = mq.size();
            for (int i = 0; i < mq.size(); i++) begin
                if (key_of(in_ins_data, mgov) < key_of(mq[i], mgov)) begin
                    k = i;
                    break;
                end
            end
            gnext = mgov;
            if (pop_f) begin
                popped = mq.pop_front();
                gnext  = popped[DW-1];
            end
            if (ins_f) begin
                if (pop_f) mq.insert((k > 0) ? k - 1 : 0, in_ins_data);
                else       mq.insert(k, in_ins_data);
            end
            mgov = gnext;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("count", 64'(out_count), 64'(mq.size()));
            chk("empty", 64'(out_empty), 64'(mq.size() == 0));
            chk("full", 64'(out_full), 64'(mq.size() == DEPTH));
            chk("head_valid", 64'(out_head_valid), 64'(mq.size() != 0));
            chk("ins_ready", 64'(out_ins_ready), 64'((mq.size() < DEPTH) || in_pop));
            chk("global_ovf", 64'(out_global_overflow), 64'(mgov));
            if (mq.size() != 0) chk("head_data", 64'(out_head_data), 64'(mq[0]));
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic p);
        in_ins_valid = v;
        in_ins_data  = d;
        in_pop       = p;
        @(posedge clk);
        #1;
        in_ins_valid = 1'b0;
        in_pop       = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        started = 1'b1;
        chk("rst_empty", 64'(out_empty), 64'd1);
        chk("rst_ready", 64'(out_ins_ready), 64'd1);
        chk("rst_head_valid", 64'(out_head_valid), 64'd0);

        // Ranks 5,3,9 drain in sorted order
        step(1'b1, mk(1'b0, 5, 0), 1'b0);
        step(1'b1, mk(1'b0, 3, 0), 1'b0);
        step(1'b1, mk(1'b0, 9, 0), 1'b0);
        chk("sort_count3", 64'(out_count), 64'd3);
        chk("sort_head3", 64'(rank_of(out_head_data)), 64'd3);
        step(1'b0, '0, 1'b1);
        chk("sort_head5", 64'(rank_of(out_head_data)), 64'd5);
        step(1'b0, '0, 1'b1);
        chk("sort_head9", 64'(rank_of(out_head_data)), 64'd9);
        step(1'b0, '0, 1'b1);
        chk("sort_empty", 64'(out_empty), 64'd1);

        // Equal ranks keep arrival order
        step(1'b1, mk(1'b0, 7, 1), 1'b0);
        step(1'b1, mk(1'b0, 7, 2), 1'b0);
        chk("tie_first", 64'(out_head_data[AW-1:0]), 64'd1);
        step(1'b0, '0, 1'b1);
        chk("tie_second", 64'(out_head_data[AW-1:0]), 64'd2);
        step(1'b0, '0, 1'b1);

        // Full queue: stall without pop, accept with pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, mk(1'b0, 10 + i, i), 1'b0);
        in_ins_valid = 1'b1;
        in_ins_data  = mk(1'b0, 0, 99);
        #1;
        chk("full_flag", 64'(out_full), 64'd1);
        chk("full_stall", 64'(out_ins_ready), 64'd0);
        step(1'b1, mk(1'b0, 0, 99), 1'b1);
        chk("full_swap_count", 64'(out_count), 64'd16);
        chk("full_swap_head", 64'(rank_of(out_head_data)), 64'd0);

        // Overflow class ordering and global update
        do_reset();
        step(1'b1, mk(1'b0, 100, 0), 1'b0);
        step(1'b1, mk(1'b1, 2, 0), 1'b0);
        chk("ovf_head100", 64'(rank_of(out_head_data)), 64'd100);
        step(1'b0, '0, 1'b1);
        chk("ovf_glob0", 64'(out_global_overflow), 64'd0);
        chk("ovf_head2", 64'(rank_of(out_head_data)), 64'd2);
        step(1'b0, '0, 1'b1);
        chk("ovf_glob1", 64'(out_global_overflow), 64'd1);

        // Pop on empty is ignored; reset clears a non-empty queue
        step(1'b0, '0, 1'b1);
        chk("pop_empty_count", 64'(out_count), 64'd0);
        chk("pop_empty_glob", 64'(out_global_overflow), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b1, mk(1'b1, i, i), 1'b0);
        chk("pre_rst_count", 64'(out_count), 64'd4);
        rstn = 1'b0;
        step(1'b1, mk(1'b0, 1, 1), 1'b1);
        rstn = 1'b1;
        chk("rst_mid_count", 64'(out_count), 64'd0);
        chk("rst_mid_head", 64'(out_head_valid), 64'd0);
        chk("rst_mid_glob", 64'(out_global_overflow), 64'd0);

        // Randomized traffic with alternating fill/drain bias
        for (int c = 0; c < 4000; c++) begin
            int  pv;
            int  pp;
            logic [DW-1:0] d;
            pv = ((c / 150) % 2 == 0) ? 70 : 35;
            pp = ((c / 150) % 2 == 0) ? 30 : 65;
            d  = DW'({$urandom, $urandom});
            d[RLSB +: RW] = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 7));
            rstn = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 99) < pv, d, $urandom_range(0, 99) < pp);
            rstn = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
